// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared states, opcode/function encodings and branch target table
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    MEM,
    DONE
  } seq_state_t;

  // Major opcodes, IR[8:6]
  localparam logic [2:0] opO   = 3'd0;
  localparam logic [2:0] opADD = 3'd1;
  localparam logic [2:0] opSUB = 3'd2;
  localparam logic [2:0] opSEI = 3'd3;
  localparam logic [2:0] opCEQ = 3'd4;
  localparam logic [2:0] opCLT = 3'd5;
  localparam logic [2:0] opLW  = 3'd6;
  localparam logic [2:0] opSW  = 3'd7;

  // O-type function codes, IR[2:0]
  localparam logic [2:0] fnB0  = 3'd0;
  localparam logic [2:0] fnB1  = 3'd1;
  localparam logic [2:0] fnSLL = 3'd2;
  localparam logic [2:0] fnSRL = 3'd3;
  localparam logic [2:0] fnSRA = 3'd4;
  localparam logic [2:0] fnROL = 3'd5;

  // Branch targets are stored wider than any practical PC and truncated at the lookup
  localparam int LUT_DEPTH = 8;
  localparam int LUT_TGT_W = 16;
  localparam logic [LUT_TGT_W-1:0] BRANCH_TARGETS [LUT_DEPTH] = '{
    16'd0, 16'd8, 16'd40, 16'd64, 16'd100, 16'd200, 16'd512, 16'd1023
  };

  function automatic logic is_branch_fn(input logic [2:0] fn);
    return (fn == fnB0) || (fn == fnB1);
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - sequencer bus towards ROM, ALU, register file and data memory
interface instr_sequencer_if #(
  parameter int PC_W = 10
);
  logic            start;
  logic [8:0]      instr;
  logic            alu_flag;
  logic            alu_ovf;
  logic            alu_br_en;
  logic            mem_ready;
  logic [PC_W-1:0] pc;
  logic [2:0]      alu_op;
  logic [2:0]      alu_func;
  logic            flag_q;
  logic            ovf_q;
  logic [2:0]      ra_addr;
  logic [2:0]      rb_addr;
  logic            reg_we;
  logic            reg_wsel;
  logic            mem_req;
  logic            mem_we;
  logic            done;

  modport master (
    input  start, instr, alu_flag, alu_ovf, alu_br_en, mem_ready,
    output pc, alu_op, alu_func, flag_q, ovf_q, ra_addr, rb_addr,
           reg_we, reg_wsel, mem_req, mem_we, done
  );

  modport slave (
    output start, instr, alu_flag, alu_ovf, alu_br_en, mem_ready,
    input  pc, alu_op, alu_func, flag_q, ovf_q, ra_addr, rb_addr,
           reg_we, reg_wsel, mem_req, mem_we, done
  );
endinterface

// File: rtl/instr_sequencer_branch_lut.sv
// rtl/instr_sequencer_branch_lut.sv - combinational branch target table indexed by IR[5:3]
module instr_sequencer_branch_lut
  import instr_sequencer_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int LUT_W = 3
) (
  input  logic [LUT_W-1:0] idx,
  output logic [PC_W-1:0]  target
);

  assign target = PC_W'(BRANCH_TARGETS[idx]);

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/exec/mem control sequencer; SEQ_CYCLE_COUNT_EN adds cycle_cnt
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int PC_W    = 10,
  parameter int DONE_PC = 1023,
  parameter int LUT_W   = 3
) (
  input  logic clk,
  input  logic reset,
  instr_sequencer_if.master bus
`ifdef SEQ_CYCLE_COUNT_EN
  ,
  output logic [31:0] cycle_cnt
`endif
);

  localparam logic [PC_W-1:0] DONE_PC_V = PC_W'(DONE_PC);

  seq_state_t      state, state_next;
  logic [PC_W-1:0] pc_q, pc_next, pc_inc, lut_target;
  logic [8:0]      ir_q, ir_next;
  logic            flag_q, flag_next;
  logic            ovf_q, ovf_next;
  logic [2:0]      op, fn;
  logic [2:0]      alu_op, alu_func;
  logic            reg_we, reg_wsel, mem_req, mem_we;

  assign op     = ir_q[8:6];
  assign fn     = ir_q[2:0];
  assign pc_inc = pc_q + 1'b1;

  instr_sequencer_branch_lut #(
    .PC_W  (PC_W),
    .LUT_W (LUT_W)
  ) u_branch_lut (
    .idx    (LUT_W'(ir_q[5:3])),
    .target (lut_target)
  );

  // State and architectural registers; reset drops every strobe on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pc_q   <= '0;
      ir_q   <= '0;
      flag_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state  <= state_next;
      pc_q   <= pc_next;
      ir_q   <= ir_next;
      flag_q <= flag_next;
      ovf_q  <= ovf_next;
    end
  end

  // Next-state, next-PC and per-state strobes
  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    ir_next    = ir_q;
    flag_next  = flag_q;
    ovf_next   = ovf_q;
    alu_op     = 3'd0;
    alu_func   = 3'd0;
    reg_we     = 1'b0;
    reg_wsel   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE, DONE: begin
        // Flags survive a restart; only the PC is rewound
        if (bus.start) begin
          state_next = FETCH;
          pc_next    = '0;
        end
      end
      FETCH: begin
        // The end check happens before any wrap, so DONE_PC itself is never executed
        if (pc_q == DONE_PC_V) begin
          state_next = DONE;
        end else begin
          ir_next    = bus.instr;
          state_next = EXEC;
        end
      end
      EXEC: begin
        alu_op     = op;
        alu_func   = fn;
        flag_next  = bus.alu_flag;
        ovf_next   = bus.alu_ovf;
        state_next = FETCH;
        pc_next    = pc_inc;
        case (op)
          opADD, opSUB, opSEI: reg_we = 1'b1;
          opCEQ, opCLT: ;
          opLW, opSW: state_next = MEM;
          opO: begin
            if (is_branch_fn(fn)) begin
              if (bus.alu_br_en) pc_next = lut_target;
            end else begin
              reg_we = 1'b1;
            end
          end
          default: ;
        endcase
      end
      MEM: begin
        // PC already advanced in EXEC; the request is held until memory answers
        mem_req = 1'b1;
        mem_we  = (op == opSW);
        if (bus.mem_ready) begin
          state_next = FETCH;
          if (op == opLW) begin
            reg_we   = 1'b1;
            reg_wsel = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef SEQ_CYCLE_COUNT_EN
  // Busy-cycle counter: cleared by an accepted start, saturating, frozen outside a run
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else if ((state == IDLE || state == DONE) && bus.start) begin
      cycle_cnt <= '0;
    end else if ((state == FETCH || state == EXEC || state == MEM) &&
                 (cycle_cnt != 32'hFFFF_FFFF)) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`endif

  assign bus.pc       = pc_q;
  assign bus.alu_op   = alu_op;
  assign bus.alu_func = alu_func;
  assign bus.flag_q   = flag_q;
  assign bus.ovf_q    = ovf_q;
  assign bus.ra_addr  = ir_q[5:3];
  assign bus.rb_addr  = ir_q[2:0];
  assign bus.reg_we   = reg_we;
  assign bus.reg_wsel = reg_wsel;
  assign bus.mem_req  = mem_req;
  assign bus.mem_we   = mem_we;
  assign bus.done     = (state == DONE);

endmodule
